slc3_mem_arbiter: RTL and testbench
===================================

// Module: slc3_mem_arbiter
// PURPOSE
//  Sequences every memory access of the SLC-3 datapath. Arbitrates the single
//  on-board memory between two requesters: the CPU (MAR/MDR path) and the
//  program loader. Inserts configurable wait states and maps address 16'hFFFF
//  to board I/O (switch read, hex-display register write).
//  Sits between slc3 datapath/loader and the memory array, inside slc3_testtop.
// PARAMETERS
//  ADDR_W       16  memory address width; mem_addr = req_addr[ADDR_W-1:0]
//  WAIT_STATES  1   extra ACCESS cycles per transaction (0..15)
// PORTS
//  Clk        in   1       system clock, all state on rising edge
//  Reset_n    in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU request, level, held until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read
//  cpu_addr   in   16      CPU address (MAR)
//  cpu_wdata  in   16      CPU write data (MDR)
//  cpu_rdata  out  16      read data to MDR, valid while cpu_ack=1
//  cpu_ack    out  1       one-cycle completion strobe
//  ld_req     in   1       loader request, level, held until ld_ack
//  ld_we      in   1       1 = write, 0 = read
//  ld_addr    in   16      loader address
//  ld_wdata   in   16      loader write data
//  ld_rdata   out  16      loader read data, valid while ld_ack=1
//  ld_ack     out  1       one-cycle completion strobe
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  16      memory write data
//  mem_rdata  in   16      memory read data, valid by last ACCESS cycle
//  mem_en     out  1       memory enable
//  mem_we     out  1       memory write enable
//  SW         in   10      board switches (I/O read source)
//  hex_data   out  16      hex-display register (I/O write target)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; all outputs 0, incl. hex_data, rdata.
//  - FSM: IDLE -> ACCESS -> DONE -> IDLE.
//    IDLE: if ld_req, grant loader; else if cpu_req, grant CPU; latch
//      owner/we/addr/wdata; go to ACCESS. No request: stay IDLE.
//    ACCESS: lasts exactly WAIT_STATES+1 cycles (down-counter); mem_en=1,
//      mem_we=latched we, mem_addr/mem_wdata from latch. Last cycle: capture
//      mem_rdata into owner rdata register. Then go to DONE.
//    DONE: owner ack=1 for this one cycle; go to IDLE.
//  - Latency: ack high in cycle (WAIT_STATES+2) after grant edge. WAIT_STATES=1:
//    grant edge t0, ACCESS t0..t2, ack during t2..t3.
//  - Requesters deassert req in the cycle after ack. A req still high in IDLE
//    starts a new transaction (back-to-back: 1 IDLE cycle between).
//  - Both reqs high in IDLE: loader wins. No preemption: grant is held through DONE.
//    Starvation of CPU by loader is permitted.
//  - Inputs changing during ACCESS are ignored (latched copy used).
//  - rdata registers hold value until next read by same owner; writes leave
//    rdata unchanged.
//  - Address wrap: upper 16-ADDR_W bits ignored (aliasing).
//  - Reset mid-ACCESS: mem_en/mem_we drop immediately; no ack issued.
// CONFIGURATION
//  SLC3_MMIO_EN defined: address 16'hFFFF never drives mem_en. Read returns
//    {6'b0,SW} (sampled last ACCESS cycle). Write loads hex_data. Same latency.
//  SLC3_MMIO_EN undefined: 16'hFFFF is ordinary memory; hex_data tied 0.
// STRUCTURE
//  - Package slc3_mem_pkg: state enum {IDLE,ACCESS,DONE}; owner enum
//    {OWN_CPU,OWN_LD}; localparam MMIO_ADDR=16'hFFFF; struct mem_req_t
//    {we,addr,wdata}.
//  - Sub-module slc3_wait_counter: loadable down-counter, WAIT_STATES load,
//    zero flag, async active-low reset.
// TESTING
//  1 Reset: Reset_n=0 during ACCESS -> mem_en=0, acks 0, hex_data=0 immediately.
//  2 CPU write then read: cpu write 16'h3000<=16'hBEEF, then read 16'h3000 ->
//    cpu_rdata=16'hBEEF; each ack exactly 1 cycle, WAIT_STATES+2 after grant.
//  3 Contention: cpu_req and ld_req rise same edge -> ld_ack first; cpu_ack
//    follows after 1 IDLE cycle; cpu_rdata unaffected by loader read.
//  4 Wait states: WAIT_STATES=0 and 3 -> mem_en high 1 and 4 cycles; ack timing match.
//  5 MMIO (SLC3_MMIO_EN): SW=10'h3FF, read 16'hFFFF -> rdata 16'h03FF, mem_en=0;
//    write 16'h1234 to 16'hFFFF -> hex_data=16'h1234. Without macro: memory
//    access occurs.
//  6 Input hold: change cpu_addr mid-ACCESS -> mem_addr stays at latched value.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory arbiter.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

    localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

    // True when an address selects the board I/O location.
    function automatic logic is_mmio_addr(input logic [15:0] addr);
        return (addr == MMIO_ADDR);
    endfunction

endpackage

// File: rtl/slc3_wait_counter.sv
// Loadable down-counter that times the ACCESS phase of a memory transaction.
// Loaded with WAIT_STATES at grant; zero flag marks the final ACCESS cycle.
module slc3_wait_counter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam logic [3:0] LOAD_VAL = 4'(WAIT_STATES);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: reload on grant, otherwise count down to zero and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/slc3_mem_arbiter.sv
// SLC-3 memory arbiter: loader/CPU arbitration, wait-state insertion and
// board I/O mapping. Optional macro SLC3_MMIO_EN maps 16'hFFFF to SW/hex_data;
// without it 16'hFFFF is ordinary memory and hex_data stays 0.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_ack,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [15:0]       ld_addr,
    input  logic [15:0]       ld_wdata,
    output logic [15:0]       ld_rdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [9:0]        SW,
    output logic [15:0]       hex_data
);

`ifdef SLC3_MMIO_EN
    localparam bit MMIO_ENABLE = 1'b1;
`else
    localparam bit MMIO_ENABLE = 1'b0;
`endif

    state_t   state_q, state_d;
    owner_t   owner_q, owner_d;
    mem_req_t req_q, req_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] ld_rdata_q, ld_rdata_d;
    logic [15:0] hex_q, hex_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        ld_ack_q, ld_ack_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;

    logic        cnt_load_s;
    logic        cnt_en_s;
    logic        cnt_zero_s;
    logic        mmio_s;
    logic        mmio_next_s;
    logic [15:0] rd_val_s;

    slc3_wait_counter #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait_counter (
        .clk  (Clk),
        .rst_n(Reset_n),
        .load (cnt_load_s),
        .en   (cnt_en_s),
        .zero (cnt_zero_s)
    );

    assign mmio_s      = MMIO_ENABLE && is_mmio_addr(req_q.addr);
    assign mmio_next_s = MMIO_ENABLE && is_mmio_addr(req_d.addr);

    // Next-state, grant latching, read capture and registered output strobes.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        hex_d       = hex_q;
        cpu_ack_d   = 1'b0;
        ld_ack_d    = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_en_s    = 1'b0;
        rd_val_s    = mmio_s ? {6'b000000, SW} : mem_rdata;
        case (state_q)
            IDLE: begin
                // Loader has fixed priority over the CPU.
                if (ld_req) begin
                    owner_d    = OWN_LD;
                    req_d      = '{we: ld_we, addr: ld_addr, wdata: ld_wdata};
                    cnt_load_s = 1'b1;
                    state_d    = ACCESS;
                end else if (cpu_req) begin
                    owner_d    = OWN_CPU;
                    req_d      = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
                    cnt_load_s = 1'b1;
                    state_d    = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                cnt_en_s = 1'b1;
                if (cnt_zero_s) begin
                    state_d = DONE;
                    if (owner_q == OWN_LD) begin
                        ld_ack_d = 1'b1;
                    end else begin
                        cpu_ack_d = 1'b1;
                    end
                    if (!req_q.we) begin
                        if (owner_q == OWN_LD) begin
                            ld_rdata_d = rd_val_s;
                        end else begin
                            cpu_rdata_d = rd_val_s;
                        end
                    end else if (mmio_s) begin
                        hex_d = req_q.wdata;
                    end else begin
                        hex_d = hex_q;
                    end
                end else begin
                    state_d = ACCESS;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The I/O location never reaches the memory array.
        mem_en_d = (state_d == ACCESS) && !mmio_next_s;
        mem_we_d = mem_en_d && req_d.we;
    end

    // State, latched request and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            req_q       <= '{we: 1'b0, addr: 16'h0000, wdata: 16'h0000};
            cpu_rdata_q <= 16'h0000;
            ld_rdata_q  <= 16'h0000;
            hex_q       <= 16'h0000;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_q       <= req_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            hex_q       <= hex_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_rdata  = ld_rdata_q;
    assign ld_ack    = ld_ack_q;
    assign mem_addr  = req_q.addr[ADDR_W-1:0];
    assign mem_wdata = req_q.wdata;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign hex_data  = hex_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed self-checking bench for slc3_mem_arbiter. Main instance uses
// WAIT_STATES=1 with a behavioural memory; two extra instances cover
// WAIT_STATES=0 and WAIT_STATES=3 (the latter with a 12-bit address).
module tb_slc3_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        cpu_req, cpu_we, ld_req, ld_we;
    logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic [9:0]  SW;
    logic [15:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata, hex_data;
    logic        cpu_ack, ld_ack, mem_en, mem_we;

    logic        req0, ack0, en0, we0, ldack0;
    logic [15:0] rd0, ldrd0, addr0, wd0, hex0;
    logic        req3, ack3, en3, we3, ldack3;
    logic [15:0] rd3, ldrd3, wd3, hex3;
    logic [11:0] addr3;

    logic [15:0] mem [0:65535];

    int compared = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    slc3_mem_arbiter #(.ADDR_W(16), .WAIT_STATES(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .SW(SW), .hex_data(hex_data)
    );

    slc3_mem_arbiter #(.ADDR_W(16), .WAIT_STATES(0)) dut_ws0 (
        .Clk(Clk), .Reset_n(Reset_n),
        .cpu_req(req0), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(rd0), .cpu_ack(ack0),
        .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0000), .ld_wdata(16'h0000),
        .ld_rdata(ldrd0), .ld_ack(ldack0),
        .mem_addr(addr0), .mem_wdata(wd0), .mem_rdata(16'hA5A5),
        .mem_en(en0), .mem_we(we0), .SW(SW), .hex_data(hex0)
    );

    slc3_mem_arbiter #(.ADDR_W(12), .WAIT_STATES(3)) dut_ws3 (
        .Clk(Clk), .Reset_n(Reset_n),
        .cpu_req(req3), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(rd3), .cpu_ack(ack3),
        .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0000), .ld_wdata(16'h0000),
        .ld_rdata(ldrd3), .ld_ack(ldack3),
        .mem_addr(addr3), .mem_wdata(wd3), .mem_rdata(16'hA5A5),
        .mem_en(en3), .mem_we(we3), .SW(SW), .hex_data(hex3)
    );

    // Behavioural synchronous-write, asynchronous-read memory for the main instance.
    always @(posedge Clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CPU transaction on instance sel (0 main, 1 ws0, 2 ws3). lat counts
    // negedges after the grant edge up to the one showing ack.
    task automatic xfer(input int sel, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output int lat, output int en_n, output int ack_n);
        logic a, e;
        @(negedge Clk);
        cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        if (sel == 0) cpu_req = 1'b1; else if (sel == 1) req0 = 1'b1; else req3 = 1'b1;
        lat = 0; en_n = 0; ack_n = 0; rdata = 16'hDEAD;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            e = (sel == 0) ? mem_en : (sel == 1) ? en0 : en3;
            a = (sel == 0) ? cpu_ack : (sel == 1) ? ack0 : ack3;
            if (e) en_n++;
            if (a) begin
                lat = k; ack_n = 1;
                rdata = (sel == 0) ? cpu_rdata : (sel == 1) ? rd0 : rd3;
                break;
            end
        end
        cpu_req = 1'b0; req0 = 1'b0; req3 = 1'b0;
        @(negedge Clk);
        a = (sel == 0) ? cpu_ack : (sel == 1) ? ack0 : ack3;
        if (a) ack_n++;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] rd;
        int lat, en_n, ack_n, ld_lat, cpu_lat, acks;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = 16'h0000; ld_wdata = 16'h0000;
        req0 = 1'b0; req3 = 1'b0; SW = 10'h3FF;
        mem[16'h4000] = 16'h1111; mem[16'h6000] = 16'h0000; mem[16'hFFFF] = 16'h0000;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_mem_en", {15'h0, mem_en}, 16'h0000);
        chk("rst_cpu_ack", {15'h0, cpu_ack}, 16'h0000);
        chk("rst_ld_ack", {15'h0, ld_ack}, 16'h0000);
        chk("rst_hex", hex_data, 16'h0000);
        chk("rst_cpu_rdata", cpu_rdata, 16'h0000);
        Reset_n = 1'b1;

        // CPU write then read, WAIT_STATES=1
        xfer(0, 1'b1, 16'h3000, 16'hBEEF, rd, lat, en_n, ack_n);
        chk("wr_latency", 16'(lat), 16'd3);
        chk("wr_en_cycles", 16'(en_n), 16'd2);
        chk("wr_ack_width", 16'(ack_n), 16'd1);
        chk("wr_mem", mem[16'h3000], 16'hBEEF);
        xfer(0, 1'b0, 16'h3000, 16'h0000, rd, lat, en_n, ack_n);
        chk("rd_data", rd, 16'hBEEF);
        chk("rd_latency", 16'(lat), 16'd3);
        chk("rd_ack_width", 16'(ack_n), 16'd1);

        // Contention: loader wins, CPU follows after one IDLE cycle
        @(negedge Clk);
        cpu_we = 1'b0; cpu_addr = 16'h3000;
        ld_we = 1'b0; ld_addr = 16'h4000;
        cpu_req = 1'b1; ld_req = 1'b1;
        ld_lat = 0; cpu_lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            if (ld_ack && ld_lat == 0) begin
                ld_lat = k;
                chk("cont_ld_rdata", ld_rdata, 16'h1111);
                chk("cont_cpu_rdata_held", cpu_rdata, 16'hBEEF);
                ld_req = 1'b0;
            end
            if (cpu_ack) begin
                cpu_lat = k;
                chk("cont_cpu_rdata", cpu_rdata, 16'hBEEF);
                cpu_req = 1'b0;
                break;
            end
        end
        chk("cont_ld_latency", 16'(ld_lat), 16'd3);
        chk("cont_cpu_latency", 16'(cpu_lat), 16'd7);
        chk("cont_ld_rdata_held", ld_rdata, 16'h1111);

        // Wait-state variants
        xfer(1, 1'b0, 16'h0100, 16'h0000, rd, lat, en_n, ack_n);
        chk("ws0_latency", 16'(lat), 16'd2);
        chk("ws0_en_cycles", 16'(en_n), 16'd1);
        chk("ws0_ack_width", 16'(ack_n), 16'd1);
        chk("ws0_rdata", rd, 16'hA5A5);
        xfer(2, 1'b0, 16'hF345, 16'h0000, rd, lat, en_n, ack_n);
        chk("ws3_latency", 16'(lat), 16'd5);
        chk("ws3_en_cycles", 16'(en_n), 16'd4);
        chk("ws3_ack_width", 16'(ack_n), 16'd1);
        chk("ws3_addr_wrap", {4'h0, addr3}, 16'h0345);

        // Address 16'hFFFF
`ifdef SLC3_MMIO_EN
        xfer(0, 1'b0, 16'hFFFF, 16'h0000, rd, lat, en_n, ack_n);
        chk("mmio_rd_data", rd, 16'h03FF);
        chk("mmio_rd_en", 16'(en_n), 16'd0);
        chk("mmio_rd_latency", 16'(lat), 16'd3);
        xfer(0, 1'b1, 16'hFFFF, 16'h1234, rd, lat, en_n, ack_n);
        chk("mmio_wr_hex", hex_data, 16'h1234);
        chk("mmio_wr_en", 16'(en_n), 16'd0);
        chk("mmio_wr_mem_untouched", mem[16'hFFFF], 16'h0000);
`else
        xfer(0, 1'b1, 16'hFFFF, 16'h1234, rd, lat, en_n, ack_n);
        chk("ffff_wr_en", 16'(en_n), 16'd2);
        chk("ffff_hex_zero", hex_data, 16'h0000);
        xfer(0, 1'b0, 16'hFFFF, 16'h0000, rd, lat, en_n, ack_n);
        chk("ffff_rd_data", rd, 16'h1234);
        chk("ffff_rd_en", 16'(en_n), 16'd2);
`endif

        // Inputs changing mid-ACCESS are ignored
        @(negedge Clk);
        cpu_we = 1'b1; cpu_addr = 16'h5000; cpu_wdata = 16'h7777; cpu_req = 1'b1;
        @(negedge Clk);
        cpu_we = 1'b0; cpu_addr = 16'h6000; cpu_wdata = 16'h0000;
        @(negedge Clk);
        chk("hold_addr", mem_addr, 16'h5000);
        chk("hold_wdata", mem_wdata, 16'h7777);
        chk("hold_we", {15'h0, mem_we}, 16'h0001);
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge Clk);
            if (cpu_ack) begin lat = k; break; end
        end
        cpu_req = 1'b0;
        chk("hold_ack_seen", 16'(lat), 16'd1);
        chk("hold_mem_5000", mem[16'h5000], 16'h7777);
        chk("hold_mem_6000", mem[16'h6000], 16'h0000);

        // Reset in the middle of ACCESS
        repeat (2) @(negedge Clk);
        cpu_we = 1'b1; cpu_addr = 16'h3002; cpu_wdata = 16'h5555; cpu_req = 1'b1;
        @(negedge Clk);
        chk("pre_rst_mem_en", {15'h0, mem_en}, 16'h0001);
        #1 Reset_n = 1'b0;
        #1;
        chk("midrst_mem_en", {15'h0, mem_en}, 16'h0000);
        chk("midrst_mem_we", {15'h0, mem_we}, 16'h0000);
        chk("midrst_cpu_ack", {15'h0, cpu_ack}, 16'h0000);
        chk("midrst_hex", hex_data, 16'h0000);
        chk("midrst_cpu_rdata", cpu_rdata, 16'h0000);
        cpu_req = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (cpu_ack || ld_ack) acks++;
        end
        chk("postrst_no_ack", 16'(acks), 16'd0);
        xfer(0, 1'b0, 16'h3000, 16'h0000, rd, lat, en_n, ack_n);
        chk("postrst_rd_data", rd, 16'hBEEF);
        chk("postrst_latency", 16'(lat), 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
